// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one result bit per cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mf_req_i,
  input  logic             mf_sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] mf_data_o,
  output logic             stall_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic               last_iter;

  always_comb begin
    // MUL: acc holds the product being shifted right; a_q feeds multiplier bits LSB first.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (a_q[0] ? {1'b0, b_q} : '0);
    // DIV: acc[W-1:0] is the partial remainder; a_q shifts dividend out and quotient in.
    div_trial = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, b_q});
    div_rem   = div_ge ? (div_trial[WIDTH-1:0] - b_q) : div_trial[WIDTH-1:0];
    last_iter = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d   = a_i;
          b_d   = b_i;
          cnt_d = '0;
          acc_d = '0;
          if (!op_i) begin
            state_d = S_MUL;
          end else if (b_i != '0) begin
            state_d = S_DIV;
          end else begin
            hi_d    = '0;
            lo_d    = '0;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          hi_d    = acc_d[2*WIDTH-1:WIDTH];
          lo_d    = acc_d[WIDTH-1:0];
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = {{WIDTH{1'b0}}, div_rem};
        a_d   = {a_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          hi_d    = div_rem;
          lo_d    = a_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o    = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o    = (state_q == S_DONE);
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign mf_data_o = mf_sel_i ? lo_q : hi_q;
  assign stall_o   = mf_req_i & busy_o;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; HI and LO are each WIDTH bits.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
REQ-004 start  input  1  request a new operation; accepted only in IDLE.
REQ-005 op  input  1  0 = MULT (unsigned a*b), 1 = DIV (unsigned a/b).
REQ-006 a, b  input  WIDTH each  operands; sampled only on the accepting edge.
REQ-007 mf_req  input  1  datapath is executing MFHI/MFLO this cycle.
REQ-008 mf_sel  input  1  0 = read HI, 1 = read LO.
REQ-009 busy  output  1  high in MUL and DIV states.
REQ-010 done  output  1  one-cycle pulse, high only in DONE state.
REQ-011 hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-012 mf_data  output  WIDTH  combinational: mf_sel ? lo : hi.
REQ-013 stall  output  1  combinational: mf_req & busy.

Function
REQ-014 The block SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-015 IDLE transitions: start & op=0 -> MUL; start & op=1 & b!=0 -> DIV; start & op=1 & b==0 -> DONE; otherwise stay in IDLE.
REQ-016 Accepting edge actions: latch a and b into internal registers; clear the iteration counter and accumulators.
REQ-017 MUL: radix-2 shift-add, one multiplier bit per cycle, exactly WIDTH iterations, 2*WIDTH-bit unsigned product.
REQ-018 DIV: restoring division, one quotient bit per cycle, exactly WIDTH iterations.
REQ-019 On the edge completing iteration WIDTH: load {hi, lo} from the result and go to DONE.
- MULT: hi = product[2W-1:W], lo = product[W-1:0].
- DIV: lo = quotient, hi = remainder.
REQ-020 Divide by zero: on the accepting edge, hi = 0, lo = 0, go to DONE; no iteration states.
REQ-021 Latency: start accepted at edge E0 -> done high in cycle E0+WIDTH+1 (33 cycles for WIDTH=32); divide by zero -> done in cycle E0+1.
REQ-022 DONE SHALL return to IDLE unconditionally after one cycle; start is ignored in DONE.
REQ-023 start asserted in MUL, DIV or DONE SHALL be ignored and not queued.
REQ-024 Changes on a, b or op while busy SHALL have no effect on the result.
REQ-025 hi and lo SHALL keep their previous values throughout MUL and DIV; partial results SHALL never be visible.
REQ-026 stall SHALL be 0 in DONE and IDLE, so the updated hi/lo are readable in the done cycle.
REQ-027 The iteration counter SHALL be clog2(WIDTH)+1 bits wide and SHALL NOT wrap during an operation.

Reset
REQ-028 reset_n low at a posedge SHALL force: state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0, accumulators = 0.
REQ-029 Reset SHALL take priority over start and over any in-flight operation.
- An aborted operation SHALL NOT produce done.
- An aborted operation SHALL NOT update hi/lo with its result.

Verification
REQ-030 MULT a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 33, hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1-32.
REQ-031 DIV a=100, b=7 -> done in cycle 33, lo=14, hi=2; then DIV a=0x80000000, b=1 -> lo=0x80000000, hi=0.
REQ-032 DIV a=5, b=0 -> done in cycle 1, hi=0, lo=0, busy never high.
REQ-033 MULT 3*4 in flight with mf_req=1, mf_sel=1 -> stall=1 in cycles 1-32, mf_data=old lo, stall=0 and mf_data=12 in done cycle; start pulse in cycle 5 ignored.
REQ-034 reset_n low at cycle 10 of a MULT -> next cycle busy=0, hi=lo=0; no done pulse ever follows.
REQ-035 start held high continuously -> accepted at cycle 0, ignored through DONE, re-accepted on the first IDLE cycle (cycle 34).
